// File: rtl/difftest_io_source.sv
// difftest_io_source: DUT-side producer of the DifftestTopIO bundle.
// Counts per-cycle commits into difftest_step, paces SoC console bytes
// through a small FIFO, sequences trap events into an ordered exit code,
// and converts the endpoint's log/perf controls into core-side signals.
module difftest_io_source #(
  parameter int STEP_WIDTH   = 8,
  parameter int COMMIT_WIDTH = 6,
  parameter int UART_DEPTH   = 16,
  parameter int EXIT_DELAY   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic                    trap_valid,
  input  logic                    trap_good,
  input  logic [7:0]              trap_code,
  input  logic                    uart_wr_valid,
  input  logic [7:0]              uart_wr_ch,
  output logic                    uart_wr_ready,
  output logic [7:0]              uart_rd_ch,
  output logic                    log_enable,
  output logic                    perf_clean,
  output logic                    perf_dump,
  output logic [STEP_WIDTH-1:0]   difftest_step,
  output logic [63:0]             difftest_exit,
  output logic                    difftest_uart_out_valid,
  output logic [7:0]              difftest_uart_out_ch,
  input  logic                    difftest_uart_in_valid,
  input  logic [7:0]              difftest_uart_in_ch,
  input  logic [63:0]             difftest_logCtrl_begin,
  input  logic [63:0]             difftest_logCtrl_end,
  input  logic                    difftest_perfCtrl_clean,
  input  logic                    difftest_perfCtrl_dump
);

  localparam int PTR_W  = $clog2(UART_DEPTH);
  localparam int DCNT_W = $clog2(EXIT_DELAY + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EXIT  = 2'd2
  } state_t;

  // The endpoint's input-valid strobe carries no information here.
  logic unused_uart_in_valid;
  assign unused_uart_in_valid = difftest_uart_in_valid;

  // ---------------------------------------------------------------------
  // UART FIFO
  // ---------------------------------------------------------------------
  logic [7:0]   fifo_mem [UART_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic         fifo_empty;
  logic         fifo_full;
  logic         wr_accept;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // No bypass: a full FIFO refuses a byte even if a pop frees a slot now.
  assign wr_accept  = uart_wr_valid && !fifo_full;

  assign uart_wr_ready           = !fifo_full;
  assign difftest_uart_out_valid = !fifo_empty;
  assign difftest_uart_out_ch    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

  // Pointer update: accept on valid&&ready, pop the head every non-empty cycle.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept)   wr_ptr <= wr_ptr + 1'b1;
      if (!fifo_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only visible between the pointers.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; the reset pointers alone make
    // stale entries unobservable, and this lets it map onto RAM.
    if (wr_accept) fifo_mem[wr_ptr[PTR_W-1:0]] <= uart_wr_ch;
  end

  // ---------------------------------------------------------------------
  // Exit sequencing FSM
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [63:0]       exit_code_q, exit_code_d;

  // State, drain-delay counter and latched exit code registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      dcnt_q      <= '0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Next state: first trap wins; exit only after EXIT_DELAY quiet, empty cycles.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    exit_code_d = exit_code_q;
    case (state_q)
      ST_RUN: begin
        dcnt_d = '0;
        if (trap_valid) begin
          state_d     = ST_DRAIN;
          // The 8'h01 byte keeps a bad-trap code nonzero even for code 0.
          exit_code_d = trap_good ? {64{1'b1}} : {48'h0, 8'h01, trap_code};
        end
      end
      ST_DRAIN: begin
        // A byte arriving now would land after exit, so it restarts the count.
        if (fifo_empty && !wr_accept) begin
          if (dcnt_q == DCNT_W'(EXIT_DELAY - 1)) state_d = ST_EXIT;
          else                                    dcnt_d  = dcnt_q + DCNT_W'(1);
        end else begin
          dcnt_d = '0;
        end
      end
      ST_EXIT: begin
        state_d = ST_EXIT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign difftest_exit = (state_q == ST_EXIT) ? exit_code_q : 64'h0;

  // ---------------------------------------------------------------------
  // Commit step
  // ---------------------------------------------------------------------
  logic [STEP_WIDTH-1:0] commit_count;
  logic [STEP_WIDTH-1:0] step_q;

  // Population count of the commit slots.
  always_comb begin
    commit_count = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_count = commit_count + STEP_WIDTH'(commit_valid[i]);
    end
  end

  // Step register: commits are reported only while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= '0;
    else       step_q <= (state_q == ST_RUN) ? commit_count : '0;
  end

  assign difftest_step = step_q;

  // ---------------------------------------------------------------------
  // Log window, console input and perf control
  // ---------------------------------------------------------------------
  logic [63:0] cycle_cnt;
  logic        log_q;
  logic [7:0]  rd_ch_q;
  logic        clean_prev_q, dump_prev_q;
  logic        clean_pulse_q, dump_pulse_q;

  // Saturating cycle counter and registered log-window compare.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      log_q     <= 1'b0;
    end else begin
      if (cycle_cnt != {64{1'b1}}) cycle_cnt <= cycle_cnt + 64'd1;
      // An end at or below begin naturally yields an empty window.
      log_q <= (cycle_cnt >= difftest_logCtrl_begin) &&
               (cycle_cnt <  difftest_logCtrl_end);
    end
  end

  // Registered console input copy and rising-edge perf pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ch_q       <= 8'hFF;
      clean_prev_q  <= 1'b0;
      dump_prev_q   <= 1'b0;
      clean_pulse_q <= 1'b0;
      dump_pulse_q  <= 1'b0;
    end else begin
      rd_ch_q       <= difftest_uart_in_ch;
      clean_prev_q  <= difftest_perfCtrl_clean;
      dump_prev_q   <= difftest_perfCtrl_dump;
      clean_pulse_q <= difftest_perfCtrl_clean && !clean_prev_q;
      dump_pulse_q  <= difftest_perfCtrl_dump  && !dump_prev_q;
    end
  end

  assign log_enable = log_q;
  assign uart_rd_ch = rd_ch_q;
  assign perf_clean = clean_pulse_q;
  assign perf_dump  = dump_pulse_q;

endmodule

// File: tb/tb_difftest_io_source.sv
// Self-checking bench for difftest_io_source: a queue-based behavioural
// model predicts every output each cycle; directed sequences add literal
// expectations for the headline behaviours.
module tb_difftest_io_source;

  localparam int STEP_WIDTH   = 8;
  localparam int COMMIT_WIDTH = 6;
  localparam int UART_DEPTH   = 16;
  localparam int EXIT_DELAY   = 4;

  logic                    clock;
  logic                    reset;
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic                    trap_valid;
  logic                    trap_good;
  logic [7:0]              trap_code;
  logic                    uart_wr_valid;
  logic [7:0]              uart_wr_ch;
  logic                    uart_wr_ready;
  logic [7:0]              uart_rd_ch;
  logic                    log_enable;
  logic                    perf_clean;
  logic                    perf_dump;
  logic [STEP_WIDTH-1:0]   difftest_step;
  logic [63:0]             difftest_exit;
  logic                    difftest_uart_out_valid;
  logic [7:0]              difftest_uart_out_ch;
  logic                    difftest_uart_in_valid;
  logic [7:0]              difftest_uart_in_ch;
  logic [63:0]             difftest_logCtrl_begin;
  logic [63:0]             difftest_logCtrl_end;
  logic                    difftest_perfCtrl_clean;
  logic                    difftest_perfCtrl_dump;

  difftest_io_source #(
    .STEP_WIDTH  (STEP_WIDTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .UART_DEPTH  (UART_DEPTH),
    .EXIT_DELAY  (EXIT_DELAY)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .commit_valid            (commit_valid),
    .trap_valid              (trap_valid),
    .trap_good               (trap_good),
    .trap_code               (trap_code),
    .uart_wr_valid           (uart_wr_valid),
    .uart_wr_ch              (uart_wr_ch),
    .uart_wr_ready           (uart_wr_ready),
    .uart_rd_ch              (uart_rd_ch),
    .log_enable              (log_enable),
    .perf_clean              (perf_clean),
    .perf_dump               (perf_dump),
    .difftest_step           (difftest_step),
    .difftest_exit           (difftest_exit),
    .difftest_uart_out_valid (difftest_uart_out_valid),
    .difftest_uart_out_ch    (difftest_uart_out_ch),
    .difftest_uart_in_valid  (difftest_uart_in_valid),
    .difftest_uart_in_ch     (difftest_uart_in_ch),
    .difftest_logCtrl_begin  (difftest_logCtrl_begin),
    .difftest_logCtrl_end    (difftest_logCtrl_end),
    .difftest_perfCtrl_clean (difftest_perfCtrl_clean),
    .difftest_perfCtrl_dump  (difftest_perfCtrl_dump)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: console bytes as a queue, trap history as flags,
  // cycle count as a plain integer.
  // ---------------------------------------------------------------------
  logic [7:0]            mq[$];
  bit                    m_trapped;
  bit                    m_exited;
  logic [63:0]           m_code;
  int                    m_quiet;
  logic [63:0]           m_cnt;
  logic [STEP_WIDTH-1:0] m_step;
  bit                    m_log;
  logic [7:0]            m_rd;
  bit                    m_clean, m_dump;
  bit                    m_prev_clean, m_prev_dump;

  function automatic void model_reset();
    mq.delete();
    m_trapped    = 1'b0;
    m_exited     = 1'b0;
    m_code       = '0;
    m_quiet      = 0;
    m_cnt        = '0;
    m_step       = '0;
    m_log        = 1'b0;
    m_rd         = 8'hFF;
    m_clean      = 1'b0;
    m_dump       = 1'b0;
    m_prev_clean = 1'b0;
    m_prev_dump  = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  function automatic void model_step();
    bit accept;
    accept = uart_wr_valid && (mq.size() < UART_DEPTH);
    m_step = m_trapped ? '0 : STEP_WIDTH'($countones(commit_valid));
    if (!m_trapped) begin
      if (trap_valid) begin
        m_trapped = 1'b1;
        m_code    = trap_good ? {64{1'b1}} : {48'h0, 8'h01, trap_code};
        m_quiet   = 0;
      end
    end else if (!m_exited) begin
      if (mq.size() == 0 && !accept) begin
        m_quiet++;
        if (m_quiet == EXIT_DELAY) m_exited = 1'b1;
      end else begin
        m_quiet = 0;
      end
    end
    if (mq.size() != 0) void'(mq.pop_front());
    if (accept) mq.push_back(uart_wr_ch);
    m_log = (m_cnt >= difftest_logCtrl_begin) && (m_cnt < difftest_logCtrl_end);
    if (m_cnt != {64{1'b1}}) m_cnt = m_cnt + 64'd1;
    m_rd         = difftest_uart_in_ch;
    m_clean      = difftest_perfCtrl_clean && !m_prev_clean;
    m_dump       = difftest_perfCtrl_dump  && !m_prev_dump;
    m_prev_clean = difftest_perfCtrl_clean;
    m_prev_dump  = difftest_perfCtrl_dump;
  endfunction

  task automatic compare_all();
    check("step", 64'(difftest_step), 64'(m_step));
    check("exit", difftest_exit, m_exited ? m_code : 64'h0);
    check("wr_ready", 64'(uart_wr_ready), 64'(mq.size() < UART_DEPTH));
    check("out_valid", 64'(difftest_uart_out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check("out_ch", 64'(difftest_uart_out_ch), 64'(mq[0]));
    else                check("out_ch", 64'(difftest_uart_out_ch), 64'h0);
    check("log_enable", 64'(log_enable), 64'(m_log));
    check("rd_ch", 64'(uart_rd_ch), 64'(m_rd));
    check("perf_clean", 64'(perf_clean), 64'(m_clean));
    check("perf_dump", 64'(perf_dump), 64'(m_dump));
  endtask

  // Called at a falling edge with inputs applied; returns at the next one.
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic clear_inputs();
    commit_valid  = '0;
    trap_valid    = 1'b0;
    trap_good     = 1'b0;
    trap_code     = 8'h00;
    uart_wr_valid = 1'b0;
    uart_wr_ch    = 8'h00;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  int          log_hits, log_first, pulses, cleans, drops;
  int          empty_obs, exit_obs, out_bytes, since_exit;
  logic [7:0]  sent[$];
  logic [7:0]  got[$];

  initial begin
    reset                   = 1'b1;
    clear_inputs();
    difftest_uart_in_valid  = 1'b0;
    difftest_uart_in_ch     = 8'hFF;
    difftest_logCtrl_begin  = 64'd10;
    difftest_logCtrl_end    = 64'd12;
    difftest_perfCtrl_clean = 1'b0;
    difftest_perfCtrl_dump  = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    check("reset_ready", 64'(uart_wr_ready), 64'h1);
    check("reset_rd_ch", 64'(uart_rd_ch), 64'hFF);
    reset = 1'b0;

    // Commit popcount and a log window over counter values 10 and 11.
    log_hits  = 0;
    log_first = -1;
    for (int t = 0; t < 20; t++) begin
      commit_valid = (t == 2) ? 6'b101101 : 6'b000000;
      tick();
      if (t == 2) check("commit_popcount", 64'(difftest_step), 64'd4);
      if (t == 3) check("commit_after", 64'(difftest_step), 64'd0);
      if (log_enable) begin
        log_hits++;
        if (log_first < 0) log_first = t;
      end
    end
    commit_valid = '0;
    check("log_first_cnt", 64'(log_first), 64'd10);
    check("log_hits", 64'(log_hits), 64'd2);

    // Empty window: begin == end just ahead of the counter.
    difftest_logCtrl_begin = m_cnt + 64'd3;
    difftest_logCtrl_end   = m_cnt + 64'd3;
    log_hits = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (log_enable) log_hits++;
    end
    check("log_empty_window", 64'(log_hits), 64'd0);

    // Held perf levels produce a single pulse each.
    pulses = 0;
    cleans = 0;
    for (int t = 0; t < 8; t++) begin
      difftest_perfCtrl_dump  = (t < 5);
      difftest_perfCtrl_clean = (t >= 1 && t < 4);
      tick();
      if (perf_dump)  pulses++;
      if (perf_clean) cleans++;
    end
    difftest_perfCtrl_dump  = 1'b0;
    difftest_perfCtrl_clean = 1'b0;
    check("perf_dump_pulses", 64'(pulses), 64'd1);
    check("perf_clean_pulses", 64'(cleans), 64'd1);

    // 17 back-to-back bytes with the head popping every cycle.
    drops = 0;
    sent.delete();
    got.delete();
    for (int i = 0; i < 17; i++) begin
      uart_wr_valid = 1'b1;
      uart_wr_ch    = 8'($urandom);
      difftest_uart_in_ch = 8'($urandom);
      sent.push_back(uart_wr_ch);
      if (!uart_wr_ready) drops++;
      tick();
      if (difftest_uart_out_valid) got.push_back(difftest_uart_out_ch);
    end
    uart_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (difftest_uart_out_valid) got.push_back(difftest_uart_out_ch);
    end
    check("uart_ready_drops", 64'(drops), 64'd0);
    check("uart_count", 64'(got.size()), 64'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) check("uart_order", 64'(got[i]), 64'(sent[i]));

    // Good trap while console bytes keep arriving for two more cycles.
    empty_obs = -1;
    exit_obs  = -1;
    out_bytes = 0;
    for (int j = 0; j < 12; j++) begin
      trap_valid    = (j == 0);
      trap_good     = 1'b1;
      commit_valid  = (j == 0) ? 6'b000111 : 6'b111111;
      uart_wr_valid = (j < 3);
      uart_wr_ch    = 8'h41 + 8'(j);
      tick();
      if (j == 0) check("trap_cycle_step", 64'(difftest_step), 64'd3);
      if (difftest_uart_out_valid) out_bytes++;
      else if (empty_obs < 0) empty_obs = j;
      if (difftest_exit != 64'h0 && exit_obs < 0) exit_obs = j;
    end
    clear_inputs();
    check("drain_bytes", 64'(out_bytes), 64'd3);
    check("exit_after_empty", 64'(exit_obs - empty_obs), 64'(EXIT_DELAY));
    check("good_exit_code", difftest_exit, {64{1'b1}});

    // Asynchronous reset while in EXIT clears the code immediately.
    #2 reset = 1'b1;
    #1;
    check("reset_exit_clears", difftest_exit, 64'h0);
    check("reset_step_clears", 64'(difftest_step), 64'h0);
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Bad trap with code 0, then a good trap two cycles later is ignored.
    for (int j = 0; j < 12; j++) begin
      trap_valid = (j == 0) || (j == 2);
      trap_good  = (j == 2);
      trap_code  = 8'h00;
      tick();
    end
    clear_inputs();
    check("bad_exit_code", difftest_exit, 64'h0000_0000_0000_0100);
    apply_reset();

    // Randomized traffic against the model.
    since_exit = 0;
    for (int t = 0; t < 3000; t++) begin
      commit_valid  = COMMIT_WIDTH'($urandom);
      trap_valid    = ($urandom_range(0, 39) == 0);
      trap_good     = 1'($urandom);
      trap_code     = 8'($urandom);
      uart_wr_valid = ($urandom_range(0, 3) == 0);
      uart_wr_ch    = 8'($urandom);
      difftest_uart_in_ch = 8'($urandom);
      if ($urandom_range(0, 5) == 0) difftest_perfCtrl_clean = ~difftest_perfCtrl_clean;
      if ($urandom_range(0, 5) == 0) difftest_perfCtrl_dump  = ~difftest_perfCtrl_dump;
      if ($urandom_range(0, 15) == 0) begin
        difftest_logCtrl_begin = m_cnt + 64'($urandom_range(0, 20)) - 64'd6;
        difftest_logCtrl_end   = m_cnt + 64'($urandom_range(0, 30)) - 64'd6;
      end
      tick();
      if (m_exited) since_exit++;
      if (since_exit > 5 || $urandom_range(0, 199) == 0) begin
        since_exit = 0;
        apply_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
